// File: rtl/soc_system_pio_irq.sv
// soc_system_pio_irq
// Avalon-MM PIO with a DATA_WIDTH-bit output register, a synchronised input
// port, per-bit edge capture and a maskable level interrupt.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   address[2:0]        register word address
//   chipselect          slave select
//   write_n             active-low write strobe (qualified by chipselect)
//   writedata[31:0]     write data (low DATA_WIDTH bits used)
//   readdata[31:0]      combinational read mux, zero-extended
//   in_port             asynchronous input bits
//   out_port            output data register
//   irq                 |(edge_capture & mask)
//
// Register map: 0 DATA (RW), 1 IN (RO), 2 MASK (RW), 3 EDGE (R / W1C),
//               4 OUTSET (WO), 5 OUTCLR (WO), 6-7 reserved.
//
// Optional feature macro: PIO_BITSETCLR_EN
//   defined   -> OUTSET/OUTCLR perform atomic set/clear of data_out
//   undefined -> addresses 4 and 5 behave as reserved
module soc_system_pio_irq #(
  parameter int          DATA_WIDTH  = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  // Warm-up saturates once the synchroniser and prev flop hold real data.
  localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

  logic                                   wr;
  logic [DATA_WIDTH-1:0]                  wdata;

  logic [DATA_WIDTH-1:0]                  data_out_q, data_out_d;
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q, sync_d;
  logic [DATA_WIDTH-1:0]                  prev_q, prev_d;
  logic [DATA_WIDTH-1:0]                  mask_q, mask_d;
  logic [DATA_WIDTH-1:0]                  edge_capture_q, edge_capture_d;
  logic [2:0]                             warm_q, warm_d;

  logic                                   warm_done;
  logic [DATA_WIDTH-1:0]                  sync_last;
  logic [DATA_WIDTH-1:0]                  edge_raw;
  logic [DATA_WIDTH-1:0]                  edge_det;
  logic [DATA_WIDTH-1:0]                  edge_clr;
  logic [DATA_WIDTH-1:0]                  rd_mux;

  assign wr        = chipselect & ~write_n;
  assign wdata     = writedata[DATA_WIDTH-1:0];
  assign sync_last = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_q == WARM_MAX);

  // Per-bit edge detector; unsupported EDGE_TYPE values fall back to rising.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_edge
      if (EDGE_TYPE == 1) begin : g_fall
        assign edge_raw[gi] = ~sync_last[gi] & prev_q[gi];
      end else if (EDGE_TYPE == 2) begin : g_any
        assign edge_raw[gi] = sync_last[gi] ^ prev_q[gi];
      end else begin : g_rise
        assign edge_raw[gi] = sync_last[gi] & ~prev_q[gi];
      end
    end
  endgenerate

  // Detection is suppressed until the pipeline has filled after reset, so an
  // input already high at reset release is not mistaken for an edge.
  assign edge_det = warm_done ? edge_raw : '0;
  assign edge_clr = (wr && (address == 3'd3)) ? wdata : '0;

  always_comb begin
    data_out_d = data_out_q;
    mask_d     = mask_q;
    if (wr) begin
      case (address)
        3'd0: data_out_d = wdata;
        3'd2: mask_d     = wdata;
`ifdef PIO_BITSETCLR_EN
        3'd4: data_out_d = data_out_q | wdata;
        3'd5: data_out_d = data_out_q & ~wdata;
`endif
        default: ;
      endcase
    end
    // A new edge outranks a simultaneous write-1-to-clear on the same bit.
    edge_capture_d = (edge_capture_q & ~edge_clr) | edge_det;
    sync_d         = {sync_q[SYNC_STAGES-2:0], in_port};
    prev_d         = sync_last;
    warm_d         = warm_done ? warm_q : warm_q + 3'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q     <= RESET_VALUE[DATA_WIDTH-1:0];
      sync_q         <= '0;
      prev_q         <= '0;
      mask_q         <= '0;
      edge_capture_q <= '0;
      warm_q         <= 3'd0;
    end else begin
      data_out_q     <= data_out_d;
      sync_q         <= sync_d;
      prev_q         <= prev_d;
      mask_q         <= mask_d;
      edge_capture_q <= edge_capture_d;
      warm_q         <= warm_d;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux = data_out_q;
      3'd1:    rd_mux = sync_last;
      3'd2:    rd_mux = mask_q;
      3'd3:    rd_mux = edge_capture_q;
      default: rd_mux = '0;
    endcase
  end

  assign readdata = chipselect ? 32'(rd_mux) : 32'd0;
  assign out_port = data_out_q;
  assign irq      = |(edge_capture_q & mask_q);

endmodule

// File: tb/tb_soc_system_pio_irq.sv
// Self-checking bench for soc_system_pio_irq (DATA_WIDTH=32, RESET_VALUE=A5,
// rising-edge capture, two-stage synchroniser). Expected values are pushed to
// a scoreboard when stimulus is applied and popped when the DUT output is
// sampled.
module tb_soc_system_pio_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] in_port;
  logic [31:0] out_port;
  logic        irq;

  int n_vectors     = 0;
  int n_miscompares = 0;

  string       sb_tag_q[$];
  logic [31:0] sb_exp_q[$];

  always #5 clk = ~clk;

  soc_system_pio_irq #(
    .DATA_WIDTH (32),
    .RESET_VALUE(32'hA5),
    .EDGE_TYPE  (0),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .out_port  (out_port),
    .irq       (irq)
  );

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_vectors++;
    if (observed !== expected) begin
      n_miscompares++;
      $display("FAIL %s: observed %08h expected %08h", tag, observed, expected);
    end else begin
      $display("ok   %s: %08h", tag, observed);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] expected);
    sb_tag_q.push_back(tag);
    sb_exp_q.push_back(expected);
  endtask

  task automatic sb_pop_check(input logic [31:0] observed);
    string       tag;
    logic [31:0] expected;
    if (sb_exp_q.size() == 0) begin
      n_vectors++;
      n_miscompares++;
      $display("FAIL sb_underflow: observed %08h with no expected entry", observed);
    end else begin
      tag      = sb_tag_q.pop_front();
      expected = sb_exp_q.pop_front();
      check_value(tag, observed, expected);
    end
  endtask

  task automatic expect_now(input string tag, input logic [31:0] expected,
                            input logic [31:0] observed);
    sb_push(tag, expected);
    sb_pop_check(observed);
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = addr;
    writedata  = data;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] addr, input logic [31:0] expected,
                          input string tag);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = addr;
    sb_push(tag, expected);
    #1;
    sb_pop_check(readdata);
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'd0;
    in_port    = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    expect_now("rst_out_port", 32'hA5, out_port);
    expect_now("rst_irq", 32'd0, {31'd0, irq});
    reset_n = 1'b1;
    bus_read(3'd0, 32'h0000_00A5, "rd_data_rst");
    bus_read(3'd6, 32'd0, "rd_rsvd6");
    bus_read(3'd7, 32'd0, "rd_rsvd7");

    // DATA write
    bus_write(3'd0, 32'h1234_5678);
    expect_now("out_after_wr", 32'h1234_5678, out_port);
    bus_read(3'd0, 32'h1234_5678, "rd_data");
    idle(4);

    // IN through the synchroniser: still old value after one edge
    @(negedge clk);
    in_port = 32'h0F;
    bus_read(3'd1, 32'd0, "rd_in_1edge");
    bus_read(3'd1, 32'h0F, "rd_in_2edge");
    bus_read(3'd3, 32'h0F, "edge_unmasked");
    expect_now("irq_mask0", 32'd0, {31'd0, irq});
    in_port = 32'd0;
    idle(4);
    bus_read(3'd3, 32'h0F, "edge_no_fall");
    bus_write(3'd3, 32'hFFFF_FFFF);
    bus_read(3'd3, 32'd0, "edge_cleared");

    // Rising-edge capture and irq timing
    bus_write(3'd2, 32'h1);
    bus_read(3'd2, 32'h1, "rd_mask");
    @(negedge clk);
    in_port = 32'h1;
    @(posedge clk); #1;
    expect_now("irq_edge1", 32'd0, {31'd0, irq});
    @(posedge clk); #1;
    expect_now("irq_edge2", 32'd0, {31'd0, irq});
    @(posedge clk); #1;
    expect_now("irq_edge3", 32'd1, {31'd0, irq});
    bus_read(3'd3, 32'h1, "edge_bit0");
    bus_write(3'd3, 32'h1);
    expect_now("irq_after_clr", 32'd0, {31'd0, irq});
    bus_read(3'd3, 32'd0, "edge_bit0_clr");

    // Reset mid-operation with inputs high: warm-up guard
    @(negedge clk);
    reset_n = 1'b0;
    in_port = 32'hFF;
    #1;
    expect_now("rst_async_out", 32'hA5, out_port);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus_read(3'd3, 32'd0, $sformatf("warm_edge_%0d", i));
    end
    bus_read(3'd2, 32'd0, "mask_after_rst");
    in_port = 32'hEF;
    idle(4);
    in_port = 32'hFF;
    idle(4);
    bus_read(3'd3, 32'h10, "edge_bit4");
    expect_now("irq_masked_off", 32'd0, {31'd0, irq});

    // Clear/set collision on bit 2
    bus_write(3'd3, 32'hFFFF_FFFF);
    in_port = 32'hFB;
    idle(4);
    bus_read(3'd3, 32'd0, "edge_pre_coll");
    @(negedge clk);
    in_port = 32'hFF;
    @(posedge clk);
    @(posedge clk);
    bus_write(3'd3, 32'h4);
    bus_read(3'd3, 32'h4, "edge_collision");
    bus_write(3'd3, 32'h4);
    bus_read(3'd3, 32'd0, "edge_coll_clr");

    // Atomic set/clear
    bus_write(3'd0, 32'hF0);
    expect_now("out_f0", 32'hF0, out_port);
    bus_write(3'd4, 32'h0F);
`ifdef PIO_BITSETCLR_EN
    expect_now("out_set", 32'hFF, out_port);
`else
    expect_now("out_set", 32'hF0, out_port);
`endif
    bus_write(3'd5, 32'h81);
`ifdef PIO_BITSETCLR_EN
    expect_now("out_clr", 32'h7E, out_port);
`else
    expect_now("out_clr", 32'hF0, out_port);
`endif
    bus_read(3'd4, 32'd0, "rd_outset");
    bus_read(3'd5, 32'd0, "rd_outclr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/soc_system_pio_irq.md
Name: soc_system_pio_irq

Overview:
- Parametrised Avalon-MM PIO that succeeds the single-register output PIO used around the hash cores.
- Provides a DATA_WIDTH-bit output register with atomic bit set/clear and a synchronised input port.
- Adds per-bit edge capture and a maskable level interrupt to the HPS.
- Typical use: drive hash-core controls out and collect hash-done/valid strobes back in as interrupts.

Parameters:
- DATA_WIDTH, 32, width of out_port and in_port (1..32).
- RESET_VALUE, 0, reset value of the output data register.
- EDGE_TYPE, 0, edge-capture mode: 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2, number of in_port synchroniser flops (2..4).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  3  register word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe, qualified by chipselect.
- writedata  input  32  write data.
- readdata  output  32  combinational read mux output, zero-extended above DATA_WIDTH.
- in_port  input  DATA_WIDTH  asynchronous input bits.
- out_port  output  DATA_WIDTH  output data register.
- irq  output  1  level interrupt.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low. All flops clear asynchronously on reset_n low.
- Reset values: data_out = RESET_VALUE, sync chain = 0, prev = 0, mask = 0, edge_capture = 0, warm-up counter = 0. Therefore out_port = RESET_VALUE and irq = 0 during and after reset.
- Write strobe: wr = chipselect & ~write_n. Writes take effect at the next clk edge. Only writedata[DATA_WIDTH-1:0] is used.
- Register map:
  - 0 DATA: RW, data_out.
  - 1 IN: RO, synchronised in_port (last sync stage).
  - 2 MASK: RW, irq mask.
  - 3 EDGE: read edge_capture; write-1-to-clear.
  - 4 OUTSET: WO, data_out |= wdata.
  - 5 OUTCLR: WO, data_out &= ~wdata.
  - 6, 7: reserved; reads return 0, writes ignored.
- Reads: readdata = {32{chipselect}} & mux(address), zero-extended. Write-only and reserved addresses read 0. Reads have no side effects.
- Synchroniser: in_port passes through SYNC_STAGES flops (sync), then one prev flop.
- Edge detect per bit:
  - rising: sync & ~prev
  - falling: ~sync & prev
  - any: sync ^ prev
- Warm-up: a counter counts from 0 to SYNC_STAGES+1 after reset, then saturates. Edge detection is gated off until the counter saturates. This prevents spurious captures when in_port is already high at reset release.
- Edge capture latency: an in_port change set up before clk edge 1 sets edge_capture at edge SYNC_STAGES+1 (edge 3 for the default). irq rises in the same cycle.
- Edge capture hold and clear: edge_capture bits stay set until cleared by a write of 1 to EDGE. If a detected edge and a clearing write hit the same bit in the same cycle, set wins and the bit stays 1.
- irq = |(edge_capture & mask), driven directly from flops.
  - Changing MASK affects irq in the cycle after the write.
  - Clearing the last set-and-masked bit drops irq in the cycle after the write.
- EDGE_TYPE values other than 0–2 behave as 0.
- Reset asserted mid-operation: all state returns to reset values immediately and the warm-up sequence restarts.

Optional Feature:
- Macro: PIO_BITSETCLR_EN.
- Defined: OUTSET and OUTCLR at addresses 4 and 5 behave as described; each is a single-cycle read-modify-write of data_out with no software race.
- Not defined: addresses 4 and 5 are reserved (read 0, writes ignored) and the set/clear logic is not synthesised. DATA writes are unaffected either way.

Test Plan:
- Reset then read: hold reset_n low 3 cycles with RESET_VALUE=32'hA5 -> out_port = 32'hA5, irq = 0, read of addr 0 returns 32'h000000A5, read of addr 6 returns 0.
- DATA and IN registers: write 32'h1234_5678 to addr 0 -> out_port = 32'h1234_5678 at the next edge. Drive in_port = 32'h0F -> read of addr 1 returns 32'h0F after 2 edges.
- Rising-edge capture and irq: write MASK = 32'h1, then drive in_port[0] 0->1 -> edge_capture[0] = 1 and irq = 1 exactly 3 edges later. Write 32'h1 to addr 3 -> irq = 0 the next cycle.
- Warm-up guard and masking: in_port = 32'hFF held through reset release -> edge_capture stays 0 for 10 cycles. Then toggle in_port[4] low-high with MASK = 0 -> edge_capture = 32'h10, irq stays 0.
- Clear/set collision: in_port[2] rising edge detected in the same cycle as a write of 32'h4 to addr 3 -> edge_capture[2] remains 1.
- With PIO_BITSETCLR_EN defined: data_out = 32'hF0, write 32'h0F to addr 4 -> data_out = 32'hFF; then write 32'h81 to addr 5 -> data_out = 32'h7E. Without the macro, the same writes leave data_out = 32'hF0.
